// File: rtl/sprite_pkg.sv
// Shared constants, default sprite geometry/roles and slice helpers for the sprite compositor.
package sprite_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int COLOR_W  = 12;
   localparam int COORD_W  = 10;
   localparam int MAX_SPR  = 16;

   // Slot 0 is the wide missile, the rest are the 40x30 characters
   localparam logic [5*COORD_W-1:0] DEF_W_VEC   = {{4{10'd40}}, 10'd56};
   localparam logic [5*COORD_W-1:0] DEF_H_VEC   = {{4{10'd30}}, 10'd12};
   localparam logic [4:0]           DEF_HOSTILE = 5'b11100;
   localparam logic [4:0]           DEF_FRAGILE = 5'b00010;

   typedef logic [MAX_SPR*COORD_W-1:0] dim_vec_t;

   typedef enum logic [1:0] {
      EV_KEEP,
      EV_CLEAR,
      EV_SET,
      EV_COUNT
   } ev_action_e;

   function automatic logic [COORD_W-1:0] get_w(input dim_vec_t w_vec, input int idx);
      return w_vec[idx*COORD_W +: COORD_W];
   endfunction

   function automatic logic [COORD_W-1:0] get_h(input dim_vec_t h_vec, input int idx);
      return h_vec[idx*COORD_W +: COORD_W];
   endfunction

endpackage

// File: rtl/sprite_compositor_hit.sv
// One sprite's bounding-box test and ROM address generator, with the stage-0/1 enable register.
module sprite_hit_unit
   import sprite_pkg::*;
#(
   parameter logic [COORD_W-1:0] W      = 10'd40,
   parameter logic [COORD_W-1:0] H      = 10'd30,
   parameter int                 ADDR_W = 12
) (
   input  logic               clk_25Hz,
   input  logic               rst,
   input  logic [COORD_W-1:0] h_cnt,
   input  logic [COORD_W-1:0] v_cnt,
   input  logic [COORD_W-1:0] pos_x,
   input  logic [COORD_W-1:0] pos_y,
   input  logic               valid,
   output logic [ADDR_W-1:0]  rom_addr,
   output logic               en1
);

   logic [COORD_W-1:0] dx;
   logic [COORD_W-1:0] dy;
   logic               hit;
   logic [ADDR_W-1:0]  addr_next;

   assign dx = h_cnt - pos_x;
   assign dy = v_cnt - pos_y;

   // The visible-area limits keep sprites hanging off the right/bottom edge from wrapping in
   assign hit = valid && (h_cnt >= pos_x) && (dx < W) && (v_cnt >= pos_y) && (dy < H)
             && (h_cnt < COORD_W'(SCREEN_W)) && (v_cnt < COORD_W'(SCREEN_H));

   assign addr_next = ADDR_W'(32'(dy) * 32'(W) + 32'(dx));

   always_ff @(posedge clk_25Hz or negedge rst) begin
      if (!rst) begin
         rom_addr <= '0;
         en1      <= 1'b0;
      end else begin
         rom_addr <= hit ? addr_next : '0;
         en1      <= hit;
      end
   end

endmodule

// File: rtl/sprite_compositor.sv
// N-sprite compositor: per-sprite ROM addressing, priority/colour-key mixing and held collision events.
module sprite_compositor
   import sprite_pkg::*;
#(
   parameter int                         N_SPR        = 5,
   parameter logic [COORD_W*N_SPR-1:0]   W_VEC        = DEF_W_VEC,
   parameter logic [COORD_W*N_SPR-1:0]   H_VEC        = DEF_H_VEC,
   parameter int                         ADDR_W       = 12,
   parameter logic [N_SPR-1:0]           HOSTILE_MASK = DEF_HOSTILE,
   parameter logic [N_SPR-1:0]           FRAGILE_MASK = DEF_FRAGILE,
   parameter logic [COLOR_W-1:0]         TRANSP       = 12'h000,
   parameter logic [COLOR_W-1:0]         BG           = 12'hfff,
   parameter int                         HOLD_BITS    = 20
) (
   input  logic                       clk_25Hz,
   input  logic                       rst,
   input  logic [COORD_W-1:0]         h_cnt,
   input  logic [COORD_W-1:0]         v_cnt,
   input  logic [COORD_W*N_SPR-1:0]   pos_x,
   input  logic [COORD_W*N_SPR-1:0]   pos_y,
   input  logic [N_SPR-1:0]           valid,
   output logic [ADDR_W*N_SPR-1:0]    rom_addr,
   input  logic [COLOR_W*N_SPR-1:0]   rom_data,
   input  logic                       event_ack,
   output logic [COLOR_W-1:0]         Pixel,
   output logic [N_SPR-1:0]           Event,
   output logic                       event_pending
);

   localparam dim_vec_t W_ALL = dim_vec_t'(W_VEC);
   localparam dim_vec_t H_ALL = dim_vec_t'(H_VEC);
   localparam int       CNT_W = HOLD_BITS + 1;

   logic [N_SPR-1:0]   en1;
   logic [N_SPR-1:0]   die;
   logic               any_hostile;
   logic               any_friendly;
   logic [COLOR_W-1:0] pixel_next;
   logic [CNT_W-1:0]   hold_cnt;
   ev_action_e         ev_action;

   for (genvar i = 0; i < N_SPR; i++) begin : g_spr
      sprite_hit_unit #(
         .W      (get_w(W_ALL, i)),
         .H      (get_h(H_ALL, i)),
         .ADDR_W (ADDR_W)
      ) u_hit (
         .clk_25Hz (clk_25Hz),
         .rst      (rst),
         .h_cnt    (h_cnt),
         .v_cnt    (v_cnt),
         .pos_x    (pos_x[i*COORD_W +: COORD_W]),
         .pos_y    (pos_y[i*COORD_W +: COORD_W]),
         .valid    (valid[i]),
         .rom_addr (rom_addr[i*ADDR_W +: ADDR_W]),
         .en1      (en1[i])
      );
   end

   // Walk from lowest priority upward so sprite 0 overwrites everything beneath it
   always_comb begin
      pixel_next = BG;
      for (int i = N_SPR - 1; i >= 0; i--) begin
         if (en1[i] && (rom_data[i*COLOR_W +: COLOR_W] != TRANSP)) begin
            pixel_next = rom_data[i*COLOR_W +: COLOR_W];
         end
      end
   end

   always_ff @(posedge clk_25Hz or negedge rst) begin
      if (!rst) begin
         Pixel <= BG;
      end else begin
         Pixel <= pixel_next;
      end
   end

   // Collisions use bounding boxes only; like-with-like overlaps are harmless
   assign any_hostile  = |(en1 & HOSTILE_MASK);
   assign any_friendly = |(en1 & ~HOSTILE_MASK);
   assign die = (en1 & HOSTILE_MASK & {N_SPR{any_friendly}})
              | (en1 & ~HOSTILE_MASK & FRAGILE_MASK & {N_SPR{any_hostile}});

   always_comb begin
      ev_action = EV_KEEP;
      if (event_ack) begin
         ev_action = EV_CLEAR;
      end else if ((die & ~Event) != '0) begin
         ev_action = EV_SET;
      end else if ((Event != '0) && !hold_cnt[CNT_W-1]) begin
         ev_action = EV_COUNT;
      end else if (hold_cnt[CNT_W-1]) begin
         ev_action = EV_CLEAR;
      end
   end

   // Every newly seen die bit restarts the hold window
   always_ff @(posedge clk_25Hz or negedge rst) begin
      if (!rst) begin
         Event    <= '0;
         hold_cnt <= '0;
      end else begin
         unique case (ev_action)
            EV_CLEAR: begin
               Event    <= '0;
               hold_cnt <= '0;
            end
            EV_SET: begin
               Event    <= Event | die;
               hold_cnt <= '0;
            end
            EV_COUNT: hold_cnt <= hold_cnt + 1'b1;
            default:  hold_cnt <= hold_cnt;
         endcase
      end
   end

   assign event_pending = |Event;

endmodule
